// File: rtl/ibufds_gte_pkg.sv
// Shared types and constants for the GT refclk buffer cycle model.
package ibufds_gte_pkg;

    typedef enum logic [1:0] {
        OFF,
        STARTUP,
        RUN
    } refclk_state_t;

    localparam int unsigned CEB_SYNC_STAGES = 2;

    // Division ratio produced by a channel for a given select value.
    function automatic int unsigned div_ratio(input int unsigned sel);
        return 2 * (sel + 1);
    endfunction

endpackage

// File: rtl/refclk_div_ch.sv
// One programmable refclk divider channel: /2*(sel+1), 50% duty, with a
// one-cycle enable aligned to each rising edge of the divided clock.
module refclk_div_ch #(
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] sel_in,
    output logic             odiv,
    output logic             odiv_ce
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] sel;
    logic [DIV_W-1:0] sel_pend;

    // DIV_SEL is sampled at the falling toggle but only takes effect at the
    // next rising toggle, so the low phase in flight keeps its old length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sel      <= '0;
            sel_pend <= '0;
            odiv     <= 1'b0;
            odiv_ce  <= 1'b0;
        end else if (!run) begin
            cnt      <= '0;
            sel      <= sel_in;
            sel_pend <= sel_in;
            odiv     <= 1'b0;
            odiv_ce  <= 1'b0;
        end else begin
            odiv_ce <= 1'b0;
            if (cnt == sel) begin
                cnt  <= '0;
                odiv <= ~odiv;
                if (odiv) begin
                    sel_pend <= sel_in;
                end else begin
                    sel     <= sel_pend;
                    odiv_ce <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ibufds_gte_div.sv
// GT reference-clock input buffer model: CEB-driven power-up sequence,
// gated refclk output and NUM_CH independent programmable dividers.
module ibufds_gte_div
    import ibufds_gte_pkg::*;
#(
    parameter int unsigned NUM_CH            = 2,
    parameter int unsigned DIV_W             = 4,
    parameter int unsigned STARTUP_CYC       = 8,
    parameter logic        REFCLK_EN_TX_PATH = 1'b0
) (
    input  logic                    I,
    input  logic                    RSTB,
    input  logic                    CEB,
    input  logic [NUM_CH*DIV_W-1:0] DIV_SEL,
    output logic                    O,
    output logic [NUM_CH-1:0]       ODIV,
    output logic [NUM_CH-1:0]       ODIV_CE,
    output logic                    READY
);

    localparam int unsigned SCNT_W = (STARTUP_CYC > 2) ? $clog2(STARTUP_CYC) : 1;

    refclk_state_t                state;
    refclk_state_t                state_next;
    logic [SCNT_W-1:0]            scnt;
    logic [CEB_SYNC_STAGES-1:0]   ceb_sync;
    logic                         ceb_s;
    logic                         ready;
    logic                         ch_run;

    assign ceb_s = ceb_sync[CEB_SYNC_STAGES-1];

    always_ff @(posedge I or negedge RSTB) begin
        if (!RSTB) begin
            ceb_sync <= '1;
        end else begin
            ceb_sync <= {ceb_sync[CEB_SYNC_STAGES-2:0], CEB};
        end
    end

    always_ff @(posedge I or negedge RSTB) begin
        if (!RSTB) begin
            state <= OFF;
            scnt  <= '0;
        end else begin
            state <= state_next;
            scnt  <= (state == STARTUP) ? scnt + 1'b1 : '0;
        end
    end

    // The OFF->STARTUP edge is itself the first of the STARTUP_CYC edges,
    // hence the STARTUP_CYC-2 terminal count.
    always_comb begin
        state_next = state;
        case (state)
            OFF: begin
                if (!ceb_s) begin
                    state_next = (STARTUP_CYC <= 1) ? RUN : STARTUP;
                end
            end
            STARTUP: begin
                if (ceb_s) begin
                    state_next = OFF;
                end else if (scnt == SCNT_W'(STARTUP_CYC - 2)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (ceb_s) begin
                    state_next = OFF;
                end
            end
            default: state_next = OFF;
        endcase
    end

    // Channels stop on the same edge the FSM leaves RUN.
    always_comb begin
        ready  = (state == RUN);
        ch_run = ready & ~ceb_s & ~REFCLK_EN_TX_PATH;
    end

    assign READY = ready;
    assign O     = I & ready & ~REFCLK_EN_TX_PATH;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        refclk_div_ch #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk     (I),
            .rst_n   (RSTB),
            .run     (ch_run),
            .sel_in  (DIV_SEL[k*DIV_W +: DIV_W]),
            .odiv    (ODIV[k]),
            .odiv_ce (ODIV_CE[k])
        );
    end

endmodule

// File: tb/tb_ibufds_gte_div.sv
// Directed self-checking bench for ibufds_gte_div (normal and TX-path-only instances).
module tb_ibufds_gte_div;

    logic       I = 1'b0;
    logic       RSTB;
    logic       CEB;
    logic [7:0] DIV_SEL;

    logic       O, READY;
    logic [1:0] ODIV, ODIV_CE;
    logic       O_tx, READY_tx;
    logic [1:0] ODIV_tx, ODIV_CE_tx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 I = ~I;

    ibufds_gte_div #(
        .NUM_CH(2), .DIV_W(4), .STARTUP_CYC(8), .REFCLK_EN_TX_PATH(1'b0)
    ) dut (
        .I(I), .RSTB(RSTB), .CEB(CEB), .DIV_SEL(DIV_SEL),
        .O(O), .ODIV(ODIV), .ODIV_CE(ODIV_CE), .READY(READY)
    );

    ibufds_gte_div #(
        .NUM_CH(2), .DIV_W(4), .STARTUP_CYC(8), .REFCLK_EN_TX_PATH(1'b1)
    ) dut_tx (
        .I(I), .RSTB(RSTB), .CEB(CEB), .DIV_SEL(DIV_SEL),
        .O(O_tx), .ODIV(ODIV_tx), .ODIV_CE(ODIV_CE_tx), .READY(READY_tx)
    );

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge I);
            cyc++;
        end
        #1;
    endtask

    task automatic test_reset();
        RSTB    = 1'b0;
        CEB     = 1'b1;
        DIV_SEL = 8'h30;
        step(3);
        checks++;
        if (READY !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", READY); end
        checks++;
        if (ODIV !== 2'b00) begin errors++; $display("FAIL reset_odiv got %b exp 00", ODIV); end
        checks++;
        if (ODIV_CE !== 2'b00) begin errors++; $display("FAIL reset_ce got %b exp 00", ODIV_CE); end
        checks++;
        if (O !== 1'b0) begin errors++; $display("FAIL reset_o got %b exp 0 (I=%b)", O, I); end
        CEB = 1'b0;
    endtask

    task automatic test_startup();
        RSTB = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            step(1);
            checks++;
            if (READY !== (e == 9)) begin
                errors++; $display("FAIL startup_ready edge %0d got %b exp %b", e, READY, (e == 9));
            end
        end
        checks++;
        if (O !== 1'b1) begin errors++; $display("FAIL o_high got %b exp 1", O); end
        @(negedge I);
        #1;
        checks++;
        if (O !== 1'b0) begin errors++; $display("FAIL o_low got %b exp 0", O); end
    endtask

    task automatic test_divide();
        logic [1:0] exp_div, exp_ce;
        for (int j = 1; j <= 16; j++) begin
            step(1);
            exp_div = {((j / 4) % 2 == 1), j[0]};
            exp_ce  = {(j % 8 == 4), j[0]};
            checks++;
            if (ODIV !== exp_div) begin
                errors++; $display("FAIL divide_odiv j=%0d got %b exp %b", j, ODIV, exp_div);
            end
            checks++;
            if (ODIV_CE !== exp_ce) begin
                errors++; $display("FAIL divide_ce j=%0d got %b exp %b", j, ODIV_CE, exp_ce);
            end
        end
    endtask

    task automatic test_glitch_free();
        logic [0:13] e1 = 14'b11000011001100;
        logic [0:13] c1 = 14'b00000010001000;
        step(5);
        checks++;
        if (ODIV[1] !== 1'b1) begin errors++; $display("FAIL mid_high got %b exp 1", ODIV[1]); end
        DIV_SEL = 8'h10;
        for (int i = 0; i < 14; i++) begin
            step(1);
            checks++;
            if (ODIV[1] !== e1[i]) begin
                errors++; $display("FAIL resel_odiv1 j=%0d got %b exp %b", 22 + i, ODIV[1], e1[i]);
            end
            checks++;
            if (ODIV_CE[1] !== c1[i]) begin
                errors++; $display("FAIL resel_ce1 j=%0d got %b exp %b", 22 + i, ODIV_CE[1], c1[i]);
            end
        end
    endtask

    task automatic test_ceb_off();
        CEB = 1'b1;
        step(2);
        checks++;
        if (READY !== 1'b1) begin errors++; $display("FAIL ceb_early got %b exp 1", READY); end
        step(1);
        checks++;
        if ({READY, ODIV, ODIV_CE} !== 5'b0) begin
            errors++; $display("FAIL ceb_off got %b exp 00000", {READY, ODIV, ODIV_CE});
        end
        CEB = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            step(1);
            checks++;
            if (READY !== (e == 9)) begin
                errors++; $display("FAIL restart_ready edge %0d got %b exp %b", e, READY, (e == 9));
            end
        end
        step(2);
        checks++;
        if (ODIV !== 2'b10) begin errors++; $display("FAIL restart_odiv got %b exp 10", ODIV); end
        checks++;
        if (ODIV_CE !== 2'b10) begin errors++; $display("FAIL restart_ce got %b exp 10", ODIV_CE); end
    endtask

    task automatic test_async_reset();
        #2;
        RSTB = 1'b0;
        #1;
        checks++;
        if ({READY, ODIV, ODIV_CE, O} !== 6'b0) begin
            errors++; $display("FAIL async_reset got %b exp 000000 (I=%b)", {READY, ODIV, ODIV_CE, O}, I);
        end
        step(1);
        RSTB = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            step(1);
            checks++;
            if (READY !== (e == 9)) begin
                errors++; $display("FAIL recover_ready edge %0d got %b exp %b", e, READY, (e == 9));
            end
        end
        checks++;
        if (O !== 1'b1) begin errors++; $display("FAIL recover_o got %b exp 1", O); end
    endtask

    task automatic test_tx_path();
        RSTB = 1'b0;
        step(1);
        RSTB = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            step(1);
            checks++;
            if (READY_tx !== (e == 9)) begin
                errors++; $display("FAIL tx_ready edge %0d got %b exp %b", e, READY_tx, (e == 9));
            end
        end
        for (int c = 0; c < 100; c++) begin
            step(1);
            checks++;
            if ({O_tx, ODIV_tx, ODIV_CE_tx} !== 5'b0 || READY_tx !== 1'b1) begin
                errors++;
                $display("FAIL tx_quiet cyc %0d got o/odiv/ce=%b ready=%b exp 00000 1",
                         c, {O_tx, ODIV_tx, ODIV_CE_tx}, READY_tx);
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_startup();
        test_divide();
        test_glitch_free();
        test_ceb_off();
        test_async_reset();
        test_tx_path();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
